// File: rtl/exec_share_arbiter.sv
// exec_share_arbiter
//   Shares one registered execution block between two requesters
//   (port 0: decode stage, port 1: debug/monitor) with round-robin
//   priority. A granted request's operands are latched, presented to the
//   execution block for one cycle, and the result is captured after LAT
//   cycles and returned with a one-cycle Done pulse.
//
// Ports
//   Clk, Rst                 clock, async active-high reset
//   Req0/Op0/A0/B0           port 0 request and operands
//   Req1/Op1/A1/B1           port 1 request and operands
//   Gnt0, Gnt1               one-cycle grant pulses
//   Done0, Done1             one-cycle completion pulses
//   Res, Flag_out, Err       captured result/flags, reject flag (with Done)
//   Op_ex, A_ex, B_ex        drive to execution block
//   Ans_ex, Flag_ex          result/flags from execution block
//   Busy                     high whenever not idle
//
// state | meaning
// IDLE  | sample requests, pick a port, latch its operands, pulse Gnt
// ISSUE | present latched opcode to execution block (NOP if rejected)
// WAIT  | count out execution latency, capture Ans_ex/Flag_ex at zero
// DONE  | pulse Done for the granted port, Err if rejected
module exec_share_arbiter #(
  parameter int DW  = 8,
  parameter int OW  = 5,
  parameter int LAT = 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Req0,
  input  logic [OW-1:0] Op0,
  input  logic [DW-1:0] A0,
  input  logic [DW-1:0] B0,
  input  logic          Req1,
  input  logic [OW-1:0] Op1,
  input  logic [DW-1:0] A1,
  input  logic [DW-1:0] B1,
  output logic          Gnt0,
  output logic          Gnt1,
  output logic          Done0,
  output logic          Done1,
  output logic [DW-1:0] Res,
  output logic [3:0]    Flag_out,
  output logic          Err,
  output logic [OW-1:0] Op_ex,
  output logic [DW-1:0] A_ex,
  output logic [DW-1:0] B_ex,
  input  logic [DW-1:0] Ans_ex,
  input  logic [3:0]    Flag_ex,
  output logic          Busy
);

  localparam logic [OW-1:0] NOP      = OW'(3);
  // One bit per opcode: 00000-00111 minus 00011, 01000-01111 minus 01011,
  // 10100-11011.
  localparam logic [31:0]   VALID_MASK = 32'h0FF0_F7F7;
  localparam logic [1:0]    CNT_INIT = 2'(LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last;
  logic          r_port;
  logic          r_reject;
  logic          r_gnt0;
  logic          r_gnt1;
  logic [1:0]    r_cnt;
  logic [OW-1:0] r_op;
  logic [DW-1:0] r_a_ex;
  logic [DW-1:0] r_b_ex;
  logic [DW-1:0] r_res;
  logic [3:0]    r_flag;

  logic          w_any;
  logic          w_sel;
  logic [OW-1:0] w_op;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic          w_op_ok;

  // On a tie the port that did not win last time is selected.
  always_comb begin
    w_any   = Req0 | Req1;
    w_sel   = (Req0 && Req1) ? ~r_last : Req1;
    w_op    = w_sel ? Op1 : Op0;
    w_a     = w_sel ? A1 : A0;
    w_b     = w_sel ? B1 : B0;
    w_op_ok = VALID_MASK[w_op];
  end

  // A rejected opcode still passes through ISSUE (with Op_ex held at NOP)
  // so that its Done lands one cycle after its Gnt rather than on top of it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = r_reject ? DONE : WAIT;
      WAIT:    if (r_cnt == 2'd0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_last   <= 1'b1;
      r_port   <= 1'b0;
      r_reject <= 1'b0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_cnt    <= 2'd0;
      r_op     <= NOP;
      r_a_ex   <= '0;
      r_b_ex   <= '0;
      r_res    <= '0;
      r_flag   <= 4'd0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_port   <= w_sel;
            r_last   <= w_sel;
            r_op     <= w_op;
            r_reject <= ~w_op_ok;
            r_gnt0   <= ~w_sel;
            r_gnt1   <= w_sel;
            // Rejected ops never reach the execution block, so its
            // operand inputs keep the previous values.
            if (w_op_ok) begin
              r_a_ex <= w_a;
              r_b_ex <= w_b;
            end
          end
        end
        ISSUE: r_cnt <= CNT_INIT;
        WAIT: begin
          if (r_cnt == 2'd0) begin
            r_res  <= Ans_ex;
            r_flag <= Flag_ex;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Gnt0     = r_gnt0;
  assign Gnt1     = r_gnt1;
  assign Done0    = (r_state == DONE) && !r_port;
  assign Done1    = (r_state == DONE) && r_port;
  assign Err      = (r_state == DONE) && r_reject;
  assign Op_ex    = ((r_state == ISSUE) && !r_reject) ? r_op : NOP;
  assign A_ex     = r_a_ex;
  assign B_ex     = r_b_ex;
  assign Res      = r_res;
  assign Flag_out = r_flag;
  assign Busy     = (r_state != IDLE);

endmodule

// File: tb/tb_exec_share_arbiter.sv
// Bench for exec_share_arbiter: two instances (LAT=1 and LAT=3) share the
// same requester stimulus; each drives its own execution-block model.
// A transaction-level model predicts every output on every cycle.
module tb_exec_share_arbiter;

  localparam logic [4:0] NOP = 5'b00011;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic Req0 = 1'b0, Req1 = 1'b0;
  logic [4:0] Op0 = 5'd0, Op1 = 5'd0;
  logic [7:0] A0 = 8'd0, B0 = 8'd0, A1 = 8'd0, B1 = 8'd0;

  logic [1:0] gnt0, gnt1, done0, done1, err, busy;
  logic [1:0][7:0] res, aex, bex, ans;
  logic [1:0][3:0] flg, fex;
  logic [1:0][4:0] opex;

  int nchk = 0;
  int nbad = 0;
  bit chk_en = 1'b0;

  exec_share_arbiter #(.DW(8), .OW(5), .LAT(1)) u_lat1 (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .Op0(Op0), .A0(A0), .B0(B0),
    .Req1(Req1), .Op1(Op1), .A1(A1), .B1(B1),
    .Gnt0(gnt0[0]), .Gnt1(gnt1[0]), .Done0(done0[0]), .Done1(done1[0]),
    .Res(res[0]), .Flag_out(flg[0]), .Err(err[0]),
    .Op_ex(opex[0]), .A_ex(aex[0]), .B_ex(bex[0]),
    .Ans_ex(ans[0]), .Flag_ex(fex[0]), .Busy(busy[0]));

  exec_share_arbiter #(.DW(8), .OW(5), .LAT(3)) u_lat3 (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .Op0(Op0), .A0(A0), .B0(B0),
    .Req1(Req1), .Op1(Op1), .A1(A1), .B1(B1),
    .Gnt0(gnt0[1]), .Gnt1(gnt1[1]), .Done0(done0[1]), .Done1(done1[1]),
    .Res(res[1]), .Flag_out(flg[1]), .Err(err[1]),
    .Op_ex(opex[1]), .A_ex(aex[1]), .B_ex(bex[1]),
    .Ans_ex(ans[1]), .Flag_ex(fex[1]), .Busy(busy[1]));

  initial forever #5 Clk = ~Clk;

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Execution-block behaviour: {P,V,Z,C, result}
  function automatic logic [11:0] alu(logic [4:0] op, logic [7:0] a, logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic c, v;
    case (op)
      5'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      5'd1: begin
        r = a - b; c = (a >= b); v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      5'd2:    begin r = a & b; c = 1'b0; v = 1'b0; end
      default: begin r = a ^ b ^ {3'b000, op}; c = 1'b0; v = 1'b0; end
    endcase
    return {^r, v, (r == 8'd0), c, r};
  endfunction

  function automatic bit valid_op(logic [4:0] o);
    return (o <= 5'd7 && o != 5'd3) || (o >= 5'd8 && o <= 5'd15 && o != 5'd11) ||
           (o >= 5'd20 && o <= 5'd27);
  endfunction

  // Execution-block models: result appears LAT cycles after Op_ex is
  // presented; NOP holds the result register.
  logic [4:0] p_op[2][4];
  logic [7:0] p_a[2][4], p_b[2][4];

  function automatic logic [4:0] src_op(int k);
    return (lat_of(k) == 1) ? opex[k] : p_op[k][lat_of(k)-2];
  endfunction
  function automatic logic [7:0] src_a(int k);
    return (lat_of(k) == 1) ? aex[k] : p_a[k][lat_of(k)-2];
  endfunction
  function automatic logic [7:0] src_b(int k);
    return (lat_of(k) == 1) ? bex[k] : p_b[k][lat_of(k)-2];
  endfunction

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) begin
          p_op[k][i] <= NOP; p_a[k][i] <= 8'd0; p_b[k][i] <= 8'd0;
        end
      end
      ans <= '0;
      fex <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (src_op(k) != NOP) begin
          ans[k] <= alu(src_op(k), src_a(k), src_b(k)) & 12'h0FF;
          fex[k] <= 4'(alu(src_op(k), src_a(k), src_b(k)) >> 8);
        end
        p_op[k][0] <= opex[k]; p_a[k][0] <= aex[k]; p_b[k][0] <= bex[k];
        for (int i = 1; i < 4; i++) begin
          p_op[k][i] <= p_op[k][i-1]; p_a[k][i] <= p_a[k][i-1]; p_b[k][i] <= p_b[k][i-1];
        end
      end
    end
  end

  // Transaction-level reference model: age counts cycles since the
  // sampling edge; a valid op finishes at LAT+2, a rejected one at 2.
  bit         m_busy[2], m_val[2];
  int         m_age[2], m_port[2], m_last[2];
  logic [4:0] m_op[2];
  logic [7:0] m_a[2], m_b[2], e_res[2], e_aex[2], e_bex[2];
  logic [3:0] e_flg[2];

  function automatic int endc(int k);
    return m_val[k] ? lat_of(k) + 2 : 2;
  endfunction

  initial forever begin
    @(posedge Clk or posedge Rst);
    for (int k = 0; k < 2; k++) begin
      if (Rst) begin
        m_busy[k] = 0; m_val[k] = 0; m_age[k] = 0; m_port[k] = 0; m_last[k] = 1;
        m_op[k] = NOP; m_a[k] = 0; m_b[k] = 0;
        e_res[k] = 0; e_aex[k] = 0; e_bex[k] = 0; e_flg[k] = 0;
      end else if (m_busy[k]) begin
        m_age[k]++;
        if (m_age[k] > endc(k)) m_busy[k] = 0;
        else if (m_val[k] && m_age[k] == lat_of(k) + 2) begin
          e_res[k] = 8'(alu(m_op[k], m_a[k], m_b[k]));
          e_flg[k] = 4'(alu(m_op[k], m_a[k], m_b[k]) >> 8);
        end
      end else if (Req0 || Req1) begin
        m_port[k] = (Req0 && Req1) ? 1 - m_last[k] : (Req1 ? 1 : 0);
        m_last[k] = m_port[k];
        m_op[k] = m_port[k] ? Op1 : Op0;
        m_a[k]  = m_port[k] ? A1 : A0;
        m_b[k]  = m_port[k] ? B1 : B0;
        m_val[k] = valid_op(m_op[k]);
        m_busy[k] = 1; m_age[k] = 1;
        if (m_val[k]) begin e_aex[k] = m_a[k]; e_bex[k] = m_b[k]; end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge Clk);
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit eg, ed;
        logic [5:0] ectl, actl;
        eg = m_busy[k] && m_age[k] == 1;
        ed = m_busy[k] && m_age[k] == endc(k);
        ectl = {eg && m_port[k] == 0, eg && m_port[k] == 1, ed && m_port[k] == 0,
                ed && m_port[k] == 1, ed && !m_val[k], m_busy[k]};
        actl = {gnt0[k], gnt1[k], done0[k], done1[k], err[k], busy[k]};
        chk($sformatf("ctl%0d", k), 32'(actl), 32'(ectl));
        chk($sformatf("opex%0d", k), 32'(opex[k]),
            32'((eg && m_val[k]) ? m_op[k] : NOP));
        chk($sformatf("aex%0d", k), 32'(aex[k]), 32'(e_aex[k]));
        chk($sformatf("bex%0d", k), 32'(bex[k]), 32'(e_bex[k]));
        chk($sformatf("res%0d", k), 32'(res[k]), 32'(e_res[k]));
        chk($sformatf("flag%0d", k), 32'(flg[k]), 32'(e_flg[k]));
        chk($sformatf("overlap%0d", k),
            32'((done0[k] & gnt1[k]) | (done1[k] & gnt0[k]) |
                (gnt0[k] & gnt1[k]) | (done0[k] & done1[k])), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy[0] || busy[1]) && n < 200) begin tick(); n++; end
    if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    Rst = 1'b1; tick(); tick(); Rst = 1'b0; tick();
  endtask

  int g_seq[4];
  int ng, n;

  initial begin
    #1 Rst = 1'b1;
    #5 chk_en = 1'b1;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", 32'(busy[k]), 32'd0);
      chk("rst_opex", 32'(opex[k]), 32'(NOP));
      chk("rst_res", 32'(res[k]), 32'd0);
    end
    Rst = 1'b0; tick();

    // ADD 0x7F+0x01
    wait_idle();
    Req0 = 1; Op0 = 5'd0; A0 = 8'h7F; B0 = 8'h01;
    tick(); Req0 = 0;
    chk("t1_gnt0", 32'(gnt0[0]), 32'd1);
    chk("t1_opex_c1", 32'(opex[0]), 32'd0);
    tick();
    chk("t1_opex_c2", 32'(opex[0]), 32'(NOP));
    chk("t1_done_c2", 32'(done0[0]), 32'd0);
    tick();
    chk("t1_done_c3", 32'(done0[0]), 32'd1);
    chk("t1_res", 32'(res[0]), 32'h80);
    chk("t1_flag", 32'(flg[0]), 32'hC);
    chk("t1_err", 32'(err[0]), 32'd0);
    tick(); tick();
    chk("t1_lat3_done", 32'(done0[1]), 32'd1);
    chk("t1_lat3_res", 32'(res[1]), 32'h80);

    // Tie after reset: SUB on port 0 first, then AND on port 1
    wait_idle(); do_reset();
    Req0 = 1; Op0 = 5'd1; A0 = 8'h05; B0 = 8'h05;
    Req1 = 1; Op1 = 5'd2; A1 = 8'hF0; B1 = 8'h3C;
    tick(); Req0 = 0;
    chk("t2_gnt0", 32'({gnt0[0], gnt1[0]}), 32'b10);
    tick(); tick();
    chk("t2_done0", 32'(done0[0]), 32'd1);
    chk("t2_res0", 32'(res[0]), 32'h00);
    chk("t2_flag0", 32'(flg[0]), 32'h3);
    tick(); tick();
    chk("t2_gnt1_gap", 32'(gnt1[0]), 32'd1);
    Req1 = 0;
    tick(); tick();
    chk("t2_done1", 32'(done1[0]), 32'd1);
    chk("t2_res1", 32'(res[0]), 32'h30);
    chk("t2_flag1", 32'(flg[0]), 32'h0);

    // Both held: grants alternate
    wait_idle();
    Req0 = 1; Op0 = 5'd0; A0 = 8'h01; B0 = 8'h02;
    Req1 = 1; Op1 = 5'd2; A1 = 8'hF0; B1 = 8'h3C;
    ng = 0; n = 0;
    while (ng < 4 && n < 60) begin
      tick(); n++;
      if (gnt0[0] || gnt1[0]) begin g_seq[ng] = gnt1[0] ? 1 : 0; ng++; end
    end
    Req0 = 0; Req1 = 0;
    chk("t3_count", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_alt%0d", i), 32'(g_seq[i]), 32'(i % 2));

    // Invalid opcode on port 1
    wait_idle();
    Req1 = 1; Op1 = 5'b00011; A1 = 8'h55; B1 = 8'hAA;
    tick(); Req1 = 0;
    chk("t4_gnt1", 32'(gnt1[0]), 32'd1);
    chk("t4_done_c1", 32'(done1[0]), 32'd0);
    tick();
    chk("t4_done1", 32'(done1[0]), 32'd1);
    chk("t4_err", 32'(err[0]), 32'd1);
    chk("t4_res", 32'(res[0]), 32'h30);
    chk("t4_flag", 32'(flg[0]), 32'h0);
    chk("t4_opex", 32'(opex[0]), 32'(NOP));
    tick();
    chk("t4_err_off", 32'(err[0]), 32'd0);

    // Reset during WAIT
    wait_idle();
    Req0 = 1; Op0 = 5'd0; A0 = 8'h11; B0 = 8'h22;
    tick(); Req0 = 0;
    tick();
    #1 Rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t5_busy", 32'(busy[k]), 32'd0);
      chk("t5_done", 32'({done0[k], done1[k], err[k], gnt0[k], gnt1[k]}), 32'd0);
      chk("t5_ops", 32'({opex[k], aex[k], bex[k]}), 32'({NOP, 16'h0000}));
      chk("t5_res", 32'({res[k], flg[k]}), 32'd0);
    end
    tick(); Rst = 1'b0;
    tick();
    chk("t5_no_done", 32'({done0[0], done0[1]}), 32'd0);
    Req0 = 1; Req1 = 1; Op0 = 5'd0; Op1 = 5'd0;
    tick(); Req0 = 0; Req1 = 0;
    chk("t5_tie_gnt0", 32'({gnt0[0], gnt0[1]}), 32'b11);

    // LAT=3 ADD 0x10+0x20
    wait_idle();
    Req0 = 1; Op0 = 5'd0; A0 = 8'h10; B0 = 8'h20;
    tick(); Req0 = 0; n = 1;
    while (!done0[1] && n < 20) begin
      if (n >= 2) chk("t6_opex_wait", 32'(opex[1]), 32'(NOP));
      tick(); n++;
    end
    chk("t6_cycles", 32'(n), 32'd5);
    chk("t6_res", 32'(res[1]), 32'h30);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      Req0 = ($urandom_range(0, 2) != 0);
      Req1 = ($urandom_range(0, 2) != 0);
      Op0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(0, 31));
      Op1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(0, 31));
      A0 = 8'($urandom); B0 = 8'($urandom); A1 = 8'($urandom); B1 = 8'($urandom);
      Rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    Rst = 1'b0; Req0 = 0; Req1 = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end

endmodule
